// File: rtl/fxp_mult_arbiter.sv
// fxp_mult_arbiter: round-robin/burst arbiter sharing one pipelined Q8.10 multiplier among N_REQ lanes.
// Define FXP_MULT_ARB_STATS_EN to add per-requester saturating accepted-beat counters.
module fxp_mult_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WORD_WDT  = 18,
    parameter int MULT_LAT  = 5,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_vld,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*WORD_WDT-1:0]   req_op_a,
    input  logic [N_REQ*WORD_WDT-1:0]   req_op_b,
    output logic [N_REQ-1:0]            rsp_vld,
    output logic signed [WORD_WDT-1:0]  rsp_res,
    output logic                        mult_vld,
    output logic signed [WORD_WDT-1:0]  mult_op_a,
    output logic signed [WORD_WDT-1:0]  mult_op_b,
    input  logic signed [WORD_WDT-1:0]  mult_res
`ifdef FXP_MULT_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [N_REQ*16-1:0]         stat_grant_cnt
`endif
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int IW    = IDW + 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t                    state, state_nxt;
    logic [IDW-1:0]            owner, owner_nxt;
    logic [CNT_W-1:0]          burst_cnt, burst_cnt_nxt;
    logic [IDW-1:0]            rr_ptr, rr_ptr_nxt;
    logic                      gnt_found;
    logic [IDW-1:0]            gnt_id;
    logic                      xfer;
    logic [IDW-1:0]            xfer_id;
    logic                      xfer_last;
    logic signed [WORD_WDT-1:0] op_a_sel, op_b_sel;
    logic                      tag_vld_p [MULT_LAT+1];
    logic [IDW-1:0]            tag_id_p  [MULT_LAT+1];

    // First requesting lane at or after the pointer, wrapping through N_REQ-1 -> 0
    always_comb begin
        logic [IW-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + IW'(k);
            if (idx >= IW'(N_REQ))
                idx = idx - IW'(N_REQ);
            if (!gnt_found && req_vld[idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (rst_n) begin
            if (state == ARB) begin
                if (gnt_found)
                    req_rdy[gnt_id] = 1'b1;
            end else begin
                req_rdy[owner] = req_vld[owner];
            end
        end
    end

    assign xfer      = |(req_vld & req_rdy);
    assign xfer_id   = (state == ARB) ? gnt_id : owner;
    assign xfer_last = req_last[xfer_id];

    always_comb begin
        op_a_sel = '0;
        op_b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (xfer_id == IDW'(i)) begin
                op_a_sel = req_op_a[i*WORD_WDT +: WORD_WDT];
                op_b_sel = req_op_b[i*WORD_WDT +: WORD_WDT];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        rr_ptr_nxt    = rr_ptr;
        unique case (state)
            ARB: begin
                if (xfer) begin
                    rr_ptr_nxt = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    if (!xfer_last && MAX_BURST > 1) begin
                        state_nxt     = BURST;
                        owner_nxt     = gnt_id;
                        burst_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (xfer_last || burst_cnt_nxt == CNT_W'(MAX_BURST))
                        state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    // Stage p0: accepted beat issued to the multiplier, tag enters the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_vld  <= 1'b0;
            mult_op_a <= '0;
            mult_op_b <= '0;
        end else begin
            mult_vld <= xfer;
            if (xfer) begin
                mult_op_a <= op_a_sel;
                mult_op_b <= op_b_sel;
            end
        end
    end

    // Stages p1..pMULT_LAT: tag rides alongside the multiplier, tail aligned with mult_res
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= MULT_LAT; s++) begin
                tag_vld_p[s] <= 1'b0;
                tag_id_p[s]  <= '0;
            end
        end else begin
            tag_vld_p[0] <= xfer;
            tag_id_p[0]  <= xfer_id;
            for (int s = 1; s <= MULT_LAT; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end
        end
    end

    // Response stage: product routed back to its issuer, bit-exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= '0;
            rsp_res <= '0;
        end else if (tag_vld_p[MULT_LAT]) begin
            rsp_vld <= N_REQ'(1) << tag_id_p[MULT_LAT];
            rsp_res <= mult_res;
        end else begin
            rsp_vld <= '0;
        end
    end

`ifdef FXP_MULT_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stat_clr)
                    stat_grant_cnt[i*16 +: 16] <= '0;
                else if (xfer && xfer_id == IDW'(i))
                    stat_grant_cnt[i*16 +: 16] <= sat_inc16(stat_grant_cnt[i*16 +: 16]);
            end
        end
    end
`else
    // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// Randomized and directed bench for fxp_mult_arbiter against a cycle-level reference model.
// Build with FXP_MULT_ARB_STATS_EN defined to also exercise the grant counters.
module tb_fxp_mult_arbiter;

    localparam int N       = 4;
    localparam int W       = 18;
    localparam int LAT     = 5;
    localparam int MB      = 8;
    localparam int RSP_LAT = LAT + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_vld, req_rdy, req_last;
    logic [N*W-1:0] req_op_a, req_op_b;
    logic [N-1:0]   rsp_vld;
    logic [W-1:0]   rsp_res;
    logic           mult_vld;
    logic [W-1:0]   mult_op_a, mult_op_b, mult_res;
`ifdef FXP_MULT_ARB_STATS_EN
    logic           stat_clr;
    logic [N*16-1:0] stat_grant_cnt;
`endif

    always #5 clk = ~clk;

    fxp_mult_arbiter #(.N_REQ(N), .WORD_WDT(W), .MULT_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_last(req_last),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_vld(rsp_vld), .rsp_res(rsp_res),
        .mult_vld(mult_vld), .mult_op_a(mult_op_a), .mult_op_b(mult_op_b),
        .mult_res(mult_res)
`ifdef FXP_MULT_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt)
`endif
    );

    // Q8.10 product, truncated and saturated to 18 bits
    function automatic logic [W-1:0] mult_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 10;
        if (p > 131071) p = 131071;
        else if (p < -131072) p = -131072;
        return p[W-1:0];
    endfunction

    // Multiplier model with fixed latency LAT
    logic [W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mult_ref(mult_op_a, mult_op_b);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_res = mpipe[LAT-1];

    typedef struct {
        int           id;
        logic [W-1:0] res;
        int           due;
    } exp_t;

    int           n_cmp = 0, n_bad = 0;
    int           cyc = 0;
    exp_t         sb[$];
    int           m_owner, m_cnt, m_ptr;
    logic         exp_mvld;
    logic [W-1:0] exp_ma, exp_mb;
    int           rsp_cyc;
    logic [W-1:0] rsp_val;
    int           gnt_log[$];
    int           acc_id;
    int           tb_cnt[N];
    logic [N-1:0] drv_vld, drv_last;
    logic [W-1:0] drv_a[N], drv_b[N];
    int           beats[N];
    logic [N-1:0] burst, stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference arbitration: one decision per cycle from the stated rules
    function automatic int model_grant();
        int g = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && drv_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (!drv_last[g] && MB > 1) begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end
        end else if (drv_vld[m_owner]) begin
            g = m_owner;
            m_cnt++;
            if (drv_last[g] || m_cnt >= MB) m_owner = -1;
        end
        return g;
    endfunction

    task automatic clear_model();
        sb.delete();
        m_owner  = -1;
        m_cnt    = 0;
        m_ptr    = 0;
        exp_mvld = 1'b0;
        for (int i = 0; i < N; i++) begin
            tb_cnt[i] = 0;
            beats[i]  = 0;
        end
        burst    = '0;
        stall    = '0;
        drv_vld  = '0;
        drv_last = '1;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_req_rdy"}, req_rdy, '0);
        chk({pfx, "_rsp_vld"}, rsp_vld, '0);
        chk({pfx, "_rsp_res"}, rsp_res, '0);
        chk({pfx, "_mult_vld"}, mult_vld, '0);
        chk({pfx, "_mult_op_a"}, mult_op_a, '0);
        chk({pfx, "_mult_op_b"}, mult_op_b, '0);
`ifdef FXP_MULT_ARB_STATS_EN
        chk({pfx, "_stat"}, stat_grant_cnt, '0);
`endif
    endtask

    // One clock: check registered outputs, apply inputs, check req_rdy, update model
    task automatic cycle_step();
        int           exp_id;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        @(negedge clk);
        cyc++;
        chk("mult_vld", mult_vld, exp_mvld);
        if (exp_mvld) begin
            chk("mult_op_a", mult_op_a, exp_ma);
            chk("mult_op_b", mult_op_b, exp_mb);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rdy = '0;
            exp_rdy[sb[0].id] = 1'b1;
            chk("rsp_vld", rsp_vld, exp_rdy);
            chk("rsp_res", rsp_res, sb[0].res);
            void'(sb.pop_front());
        end else begin
            chk("rsp_idle", rsp_vld, '0);
        end
        if (rsp_vld != '0) begin
            rsp_cyc = cyc;
            rsp_val = rsp_res;
        end
        for (int i = 0; i < N; i++) begin
            req_op_a[i*W +: W] = drv_a[i];
            req_op_b[i*W +: W] = drv_b[i];
        end
        req_vld  = drv_vld;
        req_last = drv_last;
        #1;
        exp_id  = model_grant();
        exp_rdy = '0;
        if (exp_id >= 0) exp_rdy[exp_id] = 1'b1;
        chk("req_rdy", req_rdy, exp_rdy);
        acc_id = -1;
        for (int i = 0; i < N; i++)
            if (req_vld[i] && req_rdy[i]) acc_id = i;
        if (acc_id >= 0) gnt_log.push_back(acc_id);
        if (exp_id >= 0) begin
            exp_mvld = 1'b1;
            exp_ma   = drv_a[exp_id];
            exp_mb   = drv_b[exp_id];
            e.id     = exp_id;
            e.res    = mult_ref(drv_a[exp_id], drv_b[exp_id]);
            e.due    = cyc + RSP_LAT;
            sb.push_back(e);
            tb_cnt[exp_id]++;
        end else begin
            exp_mvld = 1'b0;
        end
    endtask

    task automatic drive_step();
        for (int i = 0; i < N; i++) begin
            drv_vld[i]  = (beats[i] > 0) && !stall[i];
            drv_last[i] = burst[i] ? (beats[i] == 1) : 1'b1;
            drv_a[i]    = W'($urandom);
            drv_b[i]    = W'($urandom);
        end
        cycle_step();
        if (acc_id >= 0 && beats[acc_id] > 0) beats[acc_id]--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req_vld  = '1;
        req_last = '1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        req_vld = '0;
        gnt_log.delete();
    endtask

    task automatic chk_log(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, gnt_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
            chk(tag, gnt_log[i], exp_q[i]);
    endtask

    initial begin
        int e[$];
        int acc_cyc, n0;
        rst_n = 1'b0;
        req_vld = '0; req_last = '0; req_op_a = '0; req_op_b = '0;
`ifdef FXP_MULT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin drv_a[i] = '0; drv_b[i] = '0; end

        // Single beat 1.5 * 2.0
        do_reset();
        rsp_cyc = -1;
        drv_vld = 4'b0001; drv_last = '1;
        drv_a[0] = 18'h00600; drv_b[0] = 18'h00800;
        cycle_step();
        acc_cyc = cyc;
        chk("t1_accept", acc_id, 0);
        drv_vld = '0;
        repeat (RSP_LAT + 3) cycle_step();
        chk("t1_latency", rsp_cyc - acc_cyc, RSP_LAT);
        chk("t1_product", rsp_val, 18'h00C00);

        // All four requesting single beats: round robin with wrap
        do_reset();
        beats[0] = 2; beats[1] = 1; beats[2] = 1; beats[3] = 1;
        repeat (8) drive_step();
        e.delete();
        for (int k = 0; k < 5; k++) e.push_back(k % N);
        chk_log("t2_rr", e);
        repeat (RSP_LAT) drive_step();

        // 12-beat burst on req2 capped at MAX_BURST, req1 waiting
        do_reset();
        beats[2] = 12; burst[2] = 1'b1;
        drive_step();
        beats[1] = 1;
        repeat (20) drive_step();
        e.delete();
        for (int k = 0; k < 8; k++) e.push_back(2);
        e.push_back(1);
        for (int k = 0; k < 4; k++) e.push_back(2);
        chk_log("t3_burst", e);

        // Burst owner stalls for 3 cycles; nobody else is granted
        do_reset();
        beats[1] = 6; burst[1] = 1'b1;
        drive_step();
        beats[3] = 2;
        repeat (2) drive_step();
        stall[1] = 1'b1;
        n0 = gnt_log.size();
        repeat (3) drive_step();
        chk("t4_stall_gnt", gnt_log.size() - n0, 0);
        stall[1] = 1'b0;
        repeat (10) drive_step();
        e.delete();
        for (int k = 0; k < 6; k++) e.push_back(1);
        e.push_back(3); e.push_back(3);
        chk_log("t4_stall", e);

        // req_last on the MAX_BURST-th beat exits once
        do_reset();
        beats[0] = 8; burst[0] = 1'b1;
        drive_step();
        beats[1] = 1;
        repeat (12) drive_step();
        e.delete();
        for (int k = 0; k < 8; k++) e.push_back(0);
        e.push_back(1);
        chk_log("t5_edge", e);

        // Reset with three products in flight
        do_reset();
        beats[0] = 3;
        repeat (4) drive_step();
        #2;
        rst_n   = 1'b0;
        req_vld = '1;
        #1;
        chk_quiet("midrst");
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        req_vld = '0;
        repeat (RSP_LAT + 5) cycle_step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                drv_vld[i]  = ($urandom_range(0, 3) != 0);
                drv_last[i] = ($urandom_range(0, 9) == 0);
                drv_a[i]    = W'($urandom);
                drv_b[i]    = W'($urandom);
            end
            cycle_step();
        end
        drv_vld = '0;
        repeat (RSP_LAT + 3) cycle_step();
        chk("rand_drain", sb.size(), 0);
`ifdef FXP_MULT_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("rand_stat", stat_grant_cnt[i*16 +: 16], tb_cnt[i]);

        // Counters: 5 beats req0, 2 beats req3, then clear
        do_reset();
        beats[0] = 5; beats[3] = 2;
        repeat (12) drive_step();
        chk("stat_cnt", stat_grant_cnt, {16'd2, 16'd0, 16'd0, 16'd5});
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("stat_clr", stat_grant_cnt, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
